imm_gen_stage: RTL and testbench
================================

Name: imm_gen_stage

Overview:
Pipelined, parametrised successor to the combinational immediate generator, sitting between fetch and decode/execute.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake.
- Classifies the format, builds the sign-extended XLEN-wide immediate and flags unsupported opcodes.
- Holds results in a 2-entry output buffer, so full throughput is kept under downstream backpressure.
- Flush input supports branch redirects.

Parameters:
XLEN, 32, immediate/output width; legal values 32 or 64
RV64_OPS, 0, when 1 (requires XLEN=64) opcode 0011011 (OP-IMM-32) decodes as I-type; otherwise illegal

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
flush_w_i  input  1  discard all buffered entries
in_valid_w_i  input  1  instr_w_i is valid
in_ready_w_o  output  1  stage can accept an instruction
instr_w_i  input  32  instruction word
out_valid_w_o  output  1  head entry valid
out_ready_w_i  input  1  consumer accepts head entry
imm_w_o  output  XLEN  immediate of head entry
imm_type_w_o  output  3  format code of head entry
instr_w_o  output  32  instruction of head entry, passed through
illegal_w_o  output  1  head opcode not recognised

Behaviour:
- Reset (asynchronous, active-high, asserted or released at any time):
  - Entry count = 0, out_valid_w_o=0, in_ready_w_o=1.
  - imm_w_o, imm_type_w_o, instr_w_o and illegal_w_o = 0.
- Handshake:
  - Push when in_valid_w_i && in_ready_w_o.
  - Pop when out_valid_w_o && out_ready_w_i.
  - Latency: a pushed instruction appears at the head on the next cycle if the buffer was empty.
- Buffer:
  - 2 entries, FIFO order, count 0..2.
  - in_ready_w_o = (count != 2), driven from registered count only; no combinational path from out_ready_w_i.
  - Push and pop in the same cycle at count 1: count stays 1; the new entry becomes head next cycle.
  - At count 2, no push is possible; a pop brings it to 1.
  - out_valid_w_o = (count != 0).
  - Head outputs are 0 when count = 0.
- Flush: count becomes 0 next cycle. Flush overrides a simultaneous push and pop; the pushed instruction is dropped.
- Decode, on instr[6:0]; code values in parentheses:
  - I (5): 0010011, 0000011, 1100111; also 0011011 when RV64_OPS=1. imm = sext(instr[31:20]).
  - S (3): 0100011. imm = sext({instr[31:25], instr[11:7]}).
  - B (4): 1100011. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U (2): 0110111, 0010111. imm = sext({instr[31:12], 12'b0}) to XLEN.
  - J (1): 1101111. imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R (0): 0110011. imm = 0, not illegal.
  - Any other opcode: type 0, imm = 0, illegal = 1.
- Sign extension always replicates instr[31] up to XLEN-1.
- Elaboration: an XLEN other than 32/64, or RV64_OPS=1 with XLEN=32, triggers a fatal error.

Optional Feature:
Macro IMM_GEN_ZICSR_EN.
- Defined: opcode 1110011 decodes as type Z (6).
  - funct3[2]=1: imm = zero-extended instr[19:15] (CSR uimm).
  - funct3[2]=0: imm = 0.
  - Not illegal in either case.
- Undefined: 1110011 is illegal with type 0 and imm 0. Type code 6 is never produced.

Decomposition:
- Package imm_gen_pkg:
  - Type codes IMM_T_R=0, IMM_T_J=1, IMM_T_U=2, IMM_T_S=3, IMM_T_B=4, IMM_T_I=5, IMM_T_Z=6.
  - Opcode constants.
  - Decode-result struct {imm, type, illegal}.
- Sub-module imm_decode: purely combinational; instr in, {imm, type, illegal} out; parametrised by XLEN and RV64_OPS.
- imm_gen_stage owns the handshake, the 2-entry buffer and flush.

Test Plan:
- Single push, XLEN=32, instr 0xFFF00093 (ADDI, imm -1), out_ready=1 -> next cycle out_valid=1, imm 0xFFFFFFFF, type 5, illegal 0.
- Backpressure: push B-type 0x80000063, then J-type 0x0000006F, with out_ready=0 -> count 2, in_ready=0. Release out_ready -> head imm 0xFFFFF000 (type 4), then 0x00000000 (type 1), in order.
- Streaming: push back-to-back every cycle with out_ready=1 for 1000 random instructions -> one output per cycle, no bubbles, all imm values match a reference model.
- XLEN=64, U-type 0x800002B7 -> imm 0xFFFFFFFF80000000. With RV64_OPS=1, 0xFFF0001B -> type 5, imm all ones.
- Flush at count 2, with a simultaneous valid push -> next cycle out_valid=0, in_ready=1; the pushed instruction never appears.
- Illegal opcode 0x0000007F -> illegal 1, imm 0, type 0. Opcode 1110011 (e.g. 0x3407D073, funct3=101, uimm 15):
  - With IMM_GEN_ZICSR_EN: type 6, imm 15, illegal 0.
  - Without it: illegal 1, imm 0.
- Assert rst_i mid-stream with count 2 -> outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// -----------------------------------------------------------------------------
// imm_gen_pkg
//   Shared definitions for the pipelined immediate generator:
//     - imm_type_e : format codes reported alongside each immediate
//     - OPC_*      : RV32/RV64 base opcodes recognised by the decoder
//     - imm_dec_t  : decode result {imm, imm_type, illegal}; imm is carried at
//                    the widest supported XLEN and narrowed by the consumer
//     - sext32     : widens a 32-bit sign-carrying value to IMM_MAX_W bits
//   Optional feature macro: IMM_GEN_ZICSR_EN (consumed in imm_decode.sv).
// -----------------------------------------------------------------------------
package imm_gen_pkg;

   localparam int IMM_MAX_W = 64;

   typedef enum logic [2:0] {
      IMM_T_R = 3'd0,
      IMM_T_J = 3'd1,
      IMM_T_U = 3'd2,
      IMM_T_S = 3'd3,
      IMM_T_B = 3'd4,
      IMM_T_I = 3'd5,
      IMM_T_Z = 3'd6
   } imm_type_e;

   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   typedef struct packed {
      logic [IMM_MAX_W-1:0] imm;
      imm_type_e            imm_type;
      logic                 illegal;
   } imm_dec_t;

   // Every immediate format carries its sign in bit 31 of the assembled
   // 32-bit value, so one helper covers all of them.
   function automatic logic [IMM_MAX_W-1:0] sext32(input logic [31:0] v);
      return {{(IMM_MAX_W-32){v[31]}}, v};
   endfunction

endpackage

// File: rtl/imm_decode.sv
// -----------------------------------------------------------------------------
// imm_decode
//   Purely combinational format classifier and immediate builder.
//   Parameters:
//     XLEN     : 32 or 64 (checked at elaboration)
//     RV64_OPS : 1 enables OP-IMM-32 (0011011) as I-type; needs XLEN=64
//   Ports:
//     instr_i [31:0] : instruction word
//     dec_o          : {imm (sign-extended to IMM_MAX_W), imm_type, illegal}
//   Macro IMM_GEN_ZICSR_EN: when defined, SYSTEM (1110011) decodes as type Z
//   with the CSR uimm (instr[19:15]) for funct3[2]=1, else imm 0. When not
//   defined SYSTEM is reported illegal like any unknown opcode.
// -----------------------------------------------------------------------------
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int RV64_OPS = 0
) (
   input  logic [31:0] instr_i,
   output imm_dec_t    dec_o
);

   if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
      $fatal(1, "imm_decode: XLEN must be 32 or 64");
   end
   if (RV64_OPS != 0 && XLEN != 64) begin : g_bad_rv64
      $fatal(1, "imm_decode: RV64_OPS=1 requires XLEN=64");
   end

   always_comb begin
      dec_o = '0;
      unique case (instr_i[6:0])
         OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
            dec_o.imm_type = IMM_T_I;
            dec_o.imm      = sext32({{20{instr_i[31]}}, instr_i[31:20]});
         end
         OPC_OP_IMM_32: begin
            if (RV64_OPS != 0) begin
               dec_o.imm_type = IMM_T_I;
               dec_o.imm      = sext32({{20{instr_i[31]}}, instr_i[31:20]});
            end else begin
               dec_o.illegal  = 1'b1;
            end
         end
         OPC_STORE: begin
            dec_o.imm_type = IMM_T_S;
            dec_o.imm      = sext32({{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]});
         end
         OPC_BRANCH: begin
            dec_o.imm_type = IMM_T_B;
            dec_o.imm      = sext32({{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                     instr_i[30:25], instr_i[11:8], 1'b0});
         end
         OPC_LUI, OPC_AUIPC: begin
            dec_o.imm_type = IMM_T_U;
            dec_o.imm      = sext32({instr_i[31:12], 12'b0});
         end
         OPC_JAL: begin
            dec_o.imm_type = IMM_T_J;
            dec_o.imm      = sext32({{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                     instr_i[20], instr_i[30:21], 1'b0});
         end
         OPC_OP: begin
            // Register-register ops carry no immediate but are legal.
            dec_o.imm_type = IMM_T_R;
         end
`ifdef IMM_GEN_ZICSR_EN
         OPC_SYSTEM: begin
            dec_o.imm_type = IMM_T_Z;
            // funct3[2] selects the immediate CSR forms (CSRRWI/SI/CI).
            if (instr_i[14]) begin
               dec_o.imm = {{(IMM_MAX_W-5){1'b0}}, instr_i[19:15]};
            end
         end
`else
         OPC_SYSTEM: begin
            dec_o.illegal = 1'b1;
         end
`endif
         default: begin
            dec_o.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_gen_stage.sv
// -----------------------------------------------------------------------------
// imm_gen_stage
//   Pipelined immediate generator between fetch and decode/execute. Each
//   accepted instruction is decoded by imm_decode and parked in a 2-entry
//   FIFO; the head entry is presented downstream.
//   Parameters: XLEN (32/64), RV64_OPS (0/1), passed to imm_decode.
//   Macro IMM_GEN_ZICSR_EN: forwarded behaviour of imm_decode (SYSTEM opcode).
//   Ports:
//     clk_i, rst_i        : clock (rising edge), async active-high reset
//     flush_w_i           : drop every buffered entry (branch redirect)
//     in_valid_w_i        : instr_w_i carries an instruction
//     in_ready_w_o        : stage can accept an instruction
//     instr_w_i [31:0]    : instruction word
//     out_valid_w_o       : head entry valid
//     out_ready_w_i       : consumer takes the head entry
//     imm_w_o [XLEN-1:0]  : head immediate
//     imm_type_w_o [2:0]  : head format code
//     instr_w_o [31:0]    : head instruction, passed through
//     illegal_w_o         : head opcode not recognised
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high; valid never waits for ready. in_ready depends only on the
//   registered entry count, so there is no combinational path from
//   out_ready_w_i to in_ready_w_o. With two entries, a full stage still
//   streams one instruction per cycle because a pop at count 1 frees room
//   for that cycle's push.
// -----------------------------------------------------------------------------
module imm_gen_stage
   import imm_gen_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int RV64_OPS = 0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_w_i,
   input  logic            in_valid_w_i,
   output logic            in_ready_w_o,
   input  logic [31:0]     instr_w_i,
   output logic            out_valid_w_o,
   input  logic            out_ready_w_i,
   output logic [XLEN-1:0] imm_w_o,
   output logic [2:0]      imm_type_w_o,
   output logic [31:0]     instr_w_o,
   output logic            illegal_w_o
);

   imm_dec_t        dec;
   logic [XLEN-1:0] dec_imm;

   imm_decode #(
      .XLEN     (XLEN),
      .RV64_OPS (RV64_OPS)
   ) u_decode (
      .instr_i (instr_w_i),
      .dec_o   (dec)
   );

   assign dec_imm = dec.imm[XLEN-1:0];

   // Bits above XLEN are copies of the sign bit and are simply not needed.
   if (XLEN < IMM_MAX_W) begin : g_imm_hi
      logic unused_imm_hi;
      assign unused_imm_hi = ^dec.imm[IMM_MAX_W-1:XLEN];
   end

   // Slot 0 is always the head; slot 1 only holds data at count 2.
   logic [1:0]      count_q;
   logic [XLEN-1:0] s0_imm_q,   s1_imm_q;
   logic [2:0]      s0_type_q,  s1_type_q;
   logic [31:0]     s0_instr_q, s1_instr_q;
   logic            s0_ill_q,   s1_ill_q;

   logic push;
   logic pop;

   assign in_ready_w_o  = (count_q != 2'd2);
   assign out_valid_w_o = (count_q != 2'd0);
   assign push          = in_valid_w_i && in_ready_w_o;
   assign pop           = out_valid_w_o && out_ready_w_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q    <= 2'd0;
         s0_imm_q   <= '0;
         s0_type_q  <= '0;
         s0_instr_q <= '0;
         s0_ill_q   <= 1'b0;
         s1_imm_q   <= '0;
         s1_type_q  <= '0;
         s1_instr_q <= '0;
         s1_ill_q   <= 1'b0;
      end else if (flush_w_i) begin
         // Flush beats any push or pop in the same cycle.
         count_q <= 2'd0;
      end else begin
         if (push && !pop) begin
            if (count_q == 2'd0) begin
               s0_imm_q   <= dec_imm;
               s0_type_q  <= dec.imm_type;
               s0_instr_q <= instr_w_i;
               s0_ill_q   <= dec.illegal;
            end else begin
               s1_imm_q   <= dec_imm;
               s1_type_q  <= dec.imm_type;
               s1_instr_q <= instr_w_i;
               s1_ill_q   <= dec.illegal;
            end
            count_q <= count_q + 2'd1;
         end else if (push && pop) begin
            // Only reachable at count 1: the new entry replaces the head.
            s0_imm_q   <= dec_imm;
            s0_type_q  <= dec.imm_type;
            s0_instr_q <= instr_w_i;
            s0_ill_q   <= dec.illegal;
         end else if (pop) begin
            s0_imm_q   <= s1_imm_q;
            s0_type_q  <= s1_type_q;
            s0_instr_q <= s1_instr_q;
            s0_ill_q   <= s1_ill_q;
            count_q    <= count_q - 2'd1;
         end
      end
   end

   // Gating by out_valid keeps the head outputs at zero whenever the buffer
   // is empty, including immediately on an asynchronous reset.
   assign imm_w_o      = out_valid_w_o ? s0_imm_q   : '0;
   assign imm_type_w_o = out_valid_w_o ? s0_type_q  : '0;
   assign instr_w_o    = out_valid_w_o ? s0_instr_q : '0;
   assign illegal_w_o  = out_valid_w_o ? s0_ill_q   : 1'b0;

endmodule

// File: tb/tb_imm_gen_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_stage
//   Self-checking bench for imm_gen_stage. A 32-bit instance is exercised
//   with a vector table, backpressure/flush/reset sequences and random
//   streaming against a reference model; a 64-bit instance with RV64_OPS=1
//   covers the wide sign extension and OP-IMM-32.
// -----------------------------------------------------------------------------
module tb_imm_gen_stage;

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   // ---------------- DUT (XLEN=32) ----------------
   logic        flush_w_i     = 1'b0;
   logic        in_valid_w_i  = 1'b0;
   logic        in_ready_w_o;
   logic [31:0] instr_w_i     = '0;
   logic        out_valid_w_o;
   logic        out_ready_w_i = 1'b0;
   logic [31:0] imm_w_o;
   logic [2:0]  imm_type_w_o;
   logic [31:0] instr_w_o;
   logic        illegal_w_o;

   imm_gen_stage #(.XLEN(32), .RV64_OPS(0)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .flush_w_i     (flush_w_i),
      .in_valid_w_i  (in_valid_w_i),
      .in_ready_w_o  (in_ready_w_o),
      .instr_w_i     (instr_w_i),
      .out_valid_w_o (out_valid_w_o),
      .out_ready_w_i (out_ready_w_i),
      .imm_w_o       (imm_w_o),
      .imm_type_w_o  (imm_type_w_o),
      .instr_w_o     (instr_w_o),
      .illegal_w_o   (illegal_w_o)
   );

   // ---------------- DUT (XLEN=64, RV64_OPS=1) ----------------
   logic        v64_in_valid = 1'b0;
   logic        v64_in_ready;
   logic [31:0] v64_instr    = '0;
   logic        v64_out_valid;
   logic [63:0] v64_imm;
   logic [2:0]  v64_type;
   logic [31:0] v64_instr_o;
   logic        v64_ill;

   imm_gen_stage #(.XLEN(64), .RV64_OPS(1)) dut64 (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .flush_w_i     (flush_w_i),
      .in_valid_w_i  (v64_in_valid),
      .in_ready_w_o  (v64_in_ready),
      .instr_w_i     (v64_instr),
      .out_valid_w_o (v64_out_valid),
      .out_ready_w_i (1'b1),
      .imm_w_o       (v64_imm),
      .imm_type_w_o  (v64_type),
      .instr_w_o     (v64_instr_o),
      .illegal_w_o   (v64_ill)
   );

   // ---------------- scoreboard ----------------
   // Record layout: {imm[31:0], type[2:0], illegal, instr[31:0]}
   logic [67:0] exp_q[$];
   logic [67:0] cur_exp = '0;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference decoder written from the instruction-format definitions.
   function automatic logic [67:0] mdl(input logic [31:0] ins);
      logic signed [11:0] i12;
      logic signed [12:0] b13;
      logic signed [20:0] j21;
      logic signed [31:0] u32;
      logic [31:0]        imm;
      logic [2:0]         t;
      logic               ill;
      imm = '0; t = 3'd0; ill = 1'b0;
      case (ins[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: begin
            i12 = ins[31:20]; imm = 32'(i12); t = 3'd5;
         end
         7'b0100011: begin
            i12 = {ins[31:25], ins[11:7]}; imm = 32'(i12); t = 3'd3;
         end
         7'b1100011: begin
            b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; imm = 32'(b13); t = 3'd4;
         end
         7'b0110111, 7'b0010111: begin
            u32 = {ins[31:12], 12'h000}; imm = u32; t = 3'd2;
         end
         7'b1101111: begin
            j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; imm = 32'(j21); t = 3'd1;
         end
         7'b0110011: begin
            t = 3'd0;
         end
`ifdef IMM_GEN_ZICSR_EN
         7'b1110011: begin
            t = 3'd6;
            imm = ins[14] ? {27'd0, ins[19:15]} : 32'd0;
         end
`endif
         default: ill = 1'b1;
      endcase
      return {imm, t, ill, ins};
   endfunction

   // One clock cycle: check at the falling edge, update the model, then
   // return 1 time unit after the next rising edge for the driver.
   task automatic tick();
      int  sz;
      bit  do_pop;
      bit  do_push;
      @(negedge clk_i);
      sz = exp_q.size();
      chk("out_valid", {95'd0, out_valid_w_o}, {95'd0, sz != 0});
      chk("in_ready",  {95'd0, in_ready_w_o},  {95'd0, sz != 2});
      if (sz == 0)
         chk("idle_head", {28'd0, imm_w_o, imm_type_w_o, illegal_w_o, instr_w_o}, 96'd0);
      else
         chk("head", {28'd0, imm_w_o, imm_type_w_o, illegal_w_o, instr_w_o}, {28'd0, exp_q[0]});
      do_pop  = (sz != 0) && out_ready_w_i;
      do_push = in_valid_w_i && (sz != 2);
      if (rst_i || flush_w_i) begin
         exp_q.delete();
      end else begin
         if (do_pop)  void'(exp_q.pop_front());
         if (do_push) exp_q.push_back(cur_exp);
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [67:0] e);
      in_valid_w_i = 1'b1;
      instr_w_i    = ins;
      cur_exp      = e;
   endtask

   task automatic drain();
      in_valid_w_i  = 1'b0;
      out_ready_w_i = 1'b1;
      for (int k = 0; k < 6 && exp_q.size() != 0; k++) tick();
      chk("drain_left", 96'(exp_q.size()), 96'd0);
      tick();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm;
      logic [2:0]  typ;
      logic        ill;
   } vec_t;

   vec_t vecs[15];

   logic [6:0] opc_list[12] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                7'b0110011, 7'b1110011, 7'b0011011, 7'b1111111};

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] ins;

      vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd5, 1'b0};
      vecs[1]  = '{32'h80000063, 32'hFFFFF000, 3'd4, 1'b0};
      vecs[2]  = '{32'h0000006F, 32'h00000000, 3'd1, 1'b0};
      vecs[3]  = '{32'h800002B7, 32'h80000000, 3'd2, 1'b0};
      vecs[4]  = '{32'h00112423, 32'h00000008, 3'd3, 1'b0};
      vecs[5]  = '{32'hFE010113, 32'hFFFFFFE0, 3'd5, 1'b0};
      vecs[6]  = '{32'h00B50533, 32'h00000000, 3'd0, 1'b0};
      vecs[7]  = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1};
`ifdef IMM_GEN_ZICSR_EN
      vecs[8]  = '{32'h3407D073, 32'h0000000F, 3'd6, 1'b0};
`else
      vecs[8]  = '{32'h3407D073, 32'h00000000, 3'd0, 1'b1};
`endif
      vecs[9]  = '{32'hFFF0001B, 32'h00000000, 3'd0, 1'b1};
      vecs[10] = '{32'h00000017, 32'h00000000, 3'd2, 1'b0};
      vecs[11] = '{32'hFFF00067, 32'hFFFFFFFF, 3'd5, 1'b0};
      vecs[12] = '{32'h00002003, 32'h00000000, 3'd5, 1'b0};
      vecs[13] = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd4, 1'b0};
      vecs[14] = '{32'h0040006F, 32'h00000004, 3'd1, 1'b0};

      // ---- reset ----
      @(posedge clk_i); #1;
      tick();
      chk("rst64_valid", {95'd0, v64_out_valid}, 96'd0);
      chk("rst64_ready", {95'd0, v64_in_ready}, 96'd1);
      rst_i = 1'b0;
      tick();

      // ---- single push, latency 1 ----
      out_ready_w_i = 1'b1;
      drive(32'hFFF00093, {32'hFFFFFFFF, 3'd5, 1'b0, 32'hFFF00093});
      tick();
      in_valid_w_i = 1'b0;
      chk("first_latency", {63'd0, out_valid_w_o, imm_w_o}, {63'd0, 1'b1, 32'hFFFFFFFF});
      tick();

      // ---- vector table ----
      for (int v = 0; v < 15; v++) begin
         drive(vecs[v].instr, {vecs[v].imm, vecs[v].typ, vecs[v].ill, vecs[v].instr});
         tick();
      end
      drain();

      // ---- backpressure: fill to 2, refuse a third, release in order ----
      out_ready_w_i = 1'b0;
      drive(32'h80000063, {32'hFFFFF000, 3'd4, 1'b0, 32'h80000063});
      tick();
      drive(32'h0000006F, {32'h00000000, 3'd1, 1'b0, 32'h0000006F});
      tick();
      chk("full_in_ready", {95'd0, in_ready_w_o}, 96'd0);
      drive(32'h00100093, mdl(32'h00100093));
      tick();
      tick();
      in_valid_w_i  = 1'b0;
      out_ready_w_i = 1'b1;
      tick();
      tick();
      chk("bp_empty", {95'd0, out_valid_w_o}, 96'd0);
      drain();

      // ---- flush at count 2 with a simultaneous push ----
      out_ready_w_i = 1'b0;
      drive(32'h00500113, mdl(32'h00500113));
      tick();
      drive(32'h00A00193, mdl(32'h00A00193));
      tick();
      flush_w_i     = 1'b1;
      out_ready_w_i = 1'($urandom_range(0, 1));
      drive(32'h12345037, mdl(32'h12345037));
      tick();
      flush_w_i    = 1'b0;
      in_valid_w_i = 1'b0;
      chk("flush_valid", {95'd0, out_valid_w_o}, 96'd0);
      chk("flush_ready", {95'd0, in_ready_w_o}, 96'd1);
      tick();
      tick();

      // ---- streaming: 1000 back-to-back pushes, no bubbles ----
      out_ready_w_i = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         ins = $urandom;
         ins[6:0] = opc_list[$urandom_range(0, 11)];
         drive(ins, mdl(ins));
         tick();
      end
      drain();

      // ---- random valid / ready mix ----
      for (int n = 0; n < 300; n++) begin
         ins = $urandom;
         ins[6:0] = opc_list[$urandom_range(0, 11)];
         drive(ins, mdl(ins));
         in_valid_w_i  = 1'($urandom_range(0, 1));
         out_ready_w_i = 1'($urandom_range(0, 1));
         tick();
      end
      drain();

      // ---- asynchronous reset mid-stream at count 2 ----
      out_ready_w_i = 1'b0;
      drive(32'hFFF00093, mdl(32'hFFFFF093 & 32'hFFF00093));
      tick();
      drive(32'h800002B7, mdl(32'h800002B7));
      tick();
      in_valid_w_i = 1'b0;
      #2;
      rst_i = 1'b1;
      #1;
      chk("arst_valid", {95'd0, out_valid_w_o}, 96'd0);
      chk("arst_ready", {95'd0, in_ready_w_o}, 96'd1);
      chk("arst_head", {28'd0, imm_w_o, imm_type_w_o, illegal_w_o, instr_w_o}, 96'd0);
      exp_q.delete();
      tick();
      rst_i = 1'b0;
      tick();

      // ---- XLEN=64 instance ----
      v64_in_valid = 1'b1;
      v64_instr    = 32'h800002B7;
      tick();
      chk("x64_u_imm",  {32'd0, v64_imm}, {32'd0, 64'hFFFFFFFF80000000});
      chk("x64_u_type", {93'd0, v64_type, v64_ill}, {93'd0, 3'd2, 1'b0});
      v64_instr = 32'hFFF0001B;
      tick();
      chk("x64_w_imm",  {32'd0, v64_imm}, {32'd0, 64'hFFFFFFFFFFFFFFFF});
      chk("x64_w_type", {93'd0, v64_type, v64_ill}, {93'd0, 3'd5, 1'b0});
      chk("x64_w_instr", {64'd0, v64_instr_o}, {64'd0, 32'hFFF0001B});
      v64_instr = 32'hFE000EE3;
      tick();
      chk("x64_b_imm",  {32'd0, v64_imm}, {32'd0, 64'hFFFFFFFFFFFFFFFC});
      v64_in_valid = 1'b0;
      tick();
      chk("x64_idle", {31'd0, v64_out_valid, v64_imm}, 96'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
